mem_arbiter: RTL

Two-requester arbiter that shares the single unified memory port between instruction fetch (IF) and the data access path (MEM stage) in the multi-cycle core. It sequences one memory transaction at a time through a three-state FSM: it registers the granted request onto the memory bus, waits for the memory acknowledge, then returns read data with a one-cycle ack pulse. Data accesses take priority, with a streak counter that prevents fetch starvation.

---
 rtl/mem_arbiter.sv | 120 ++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/data arbiter sharing one memory port, data-first with fetch starvation guard
module mem_arbiter #(
    parameter int ADDR_WIDTH  = 64,
    parameter int DATA_WIDTH  = 64,
    parameter int MAX_DSTREAK = 4
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    if_req,
    input  logic [ADDR_WIDTH-1:0]   if_addr,
    output logic                    if_ack,
    output logic [DATA_WIDTH-1:0]   if_rdata,
    input  logic                    d_req,
    input  logic                    d_we,
    input  logic [ADDR_WIDTH-1:0]   d_addr,
    input  logic [DATA_WIDTH-1:0]   d_wdata,
    input  logic [DATA_WIDTH/8-1:0] d_wmask,
    output logic                    d_ack,
    output logic [DATA_WIDTH-1:0]   d_rdata,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_wmask,
    input  logic                    mem_ack,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    output logic                    busy,
    output logic                    owner
);

    localparam int MASK_WIDTH   = DATA_WIDTH / 8;
    localparam int STREAK_WIDTH = $clog2(MAX_DSTREAK + 1);
    localparam logic [STREAK_WIDTH-1:0] STREAK_MAX = STREAK_WIDTH'(MAX_DSTREAK);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                  state;
    logic [STREAK_WIDTH-1:0] streak;
    logic                    grant_d;

    // Data wins unless a fetch has already waited through MAX_DSTREAK data grants.
    assign grant_d = d_req && (!if_req || (streak < STREAK_MAX));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            streak    <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wmask <= '0;
            if_ack    <= 1'b0;
            d_ack     <= 1'b0;
            if_rdata  <= '0;
            d_rdata   <= '0;
            owner     <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (if_req || d_req) begin
                        state   <= BUSY;
                        mem_req <= 1'b1;
                        busy    <= 1'b1;
                        owner   <= grant_d;
                        if (grant_d) begin
                            mem_we    <= d_we;
                            mem_addr  <= d_addr;
                            mem_wdata <= d_wdata;
                            mem_wmask <= d_we ? d_wmask : {MASK_WIDTH{1'b0}};
                            if (!if_req) begin
                                streak <= '0;
                            end else if (streak != STREAK_MAX) begin
                                streak <= streak + 1'b1;
                            end
                        end else begin
                            mem_we    <= 1'b0;
                            mem_addr  <= if_addr;
                            mem_wdata <= '0;
                            mem_wmask <= '0;
                            streak    <= '0;
                        end
                    end
                end
                BUSY: begin
                    if (mem_ack) begin
                        state   <= RESP;
                        mem_req <= 1'b0;
                        if (owner) begin
                            d_rdata <= mem_rdata;
                            d_ack   <= 1'b1;
                        end else begin
                            if_rdata <= mem_rdata;
                            if_ack   <= 1'b1;
                        end
                    end
                end
                RESP: begin
                    state  <= IDLE;
                    if_ack <= 1'b0;
                    d_ack  <= 1'b0;
                    busy   <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                    if_ack  <= 1'b0;
                    d_ack   <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
